// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display scan logic.
package disp_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;
endpackage

// File: rtl/digit_decoder_3to8.sv
// Combinational 3-to-8 decoder producing an active-low one-hot anode pattern.
module digit_decoder_3to8
  import disp_pkg::*;
(
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [NUM_DIGITS-1:0] an_n
);

  always_comb begin
    an_n = ANODES_OFF;
    if (en) an_n[sel] = 1'b0;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display,
// with a blanking interval at the start of every digit slot.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_en,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  lit_en;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    frame_tick_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = '0;
        end
        default: begin
          if (cnt_q == CNT_LAST) begin
            state_d      = BLANK;
            cnt_d        = '0;
            sel_d        = sel_q + SEL_W'(1);
            frame_tick_d = (sel_q == SEL_LAST);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            // cnt_d reaches BLANK_CYCLES exactly when the slot leaves blanking
            state_d = (cnt_q >= BLANK_LAST) ? SHOW : BLANK;
          end
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they line up with it once registered.
  always_comb begin
    lit_en = (state_d == SHOW) && digit_en[sel_d];
    dp_n_d = ~(lit_en & dp_en[sel_d]);
  end

  digit_decoder_3to8 u_decoder (
    .sel  (sel_d),
    .en   (lit_en),
    .an_n (an_n_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      an_n_q       <= ANODES_OFF;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      an_n_q       <= an_n_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = sel_q;
  assign an_n       = an_n_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_tick_q;

endmodule
